top_k_sorter: RTL and testbench

- Parametrised successor to the single-slot top-k cell: a K-deep sorted register array that keeps the K largest unsigned values of a framed input stream.
- On frame end (TLAST), the block streams the retained values out in descending order, then clears itself for the next frame.
- Sits between the TCP/IP RX data path and the result TX path in the top-k user kernel, with full AXI-Stream valid/ready on both sides.

---
 rtl/top_k_sorter_if.sv | 28 ++
 rtl/top_k_sorter.sv | 133 +++++++++++++
 tb/tb_top_k_sorter.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/top_k_sorter_if.sv
// AXI-Stream pair for the top-k sorter: rx carries values plus a clear flag
// in the MSB, tx carries the sorted results.
// Handshake: a beat moves on a rising edge where TVALID and TREADY are both
// high; once TVALID is raised, TDATA/TLAST/TVALID stay stable until accepted.
interface top_k_sorter_if #(
    parameter int INTEGER_SIZE = 32
);
    logic [INTEGER_SIZE:0]   rx_data_TDATA;
    logic                    rx_data_TVALID;
    logic                    rx_data_TLAST;
    logic                    rx_data_TREADY;
    logic [INTEGER_SIZE-1:0] tx_data_TDATA;
    logic                    tx_data_TVALID;
    logic                    tx_data_TLAST;
    logic                    tx_data_TREADY;

    // Source of rx / sink of tx (the surrounding kernel or a bench)
    modport master (
        output rx_data_TDATA, rx_data_TVALID, rx_data_TLAST, tx_data_TREADY,
        input  rx_data_TREADY, tx_data_TDATA, tx_data_TVALID, tx_data_TLAST
    );

    // The sorter itself
    modport slave (
        input  rx_data_TDATA, rx_data_TVALID, rx_data_TLAST, tx_data_TREADY,
        output rx_data_TREADY, tx_data_TDATA, tx_data_TVALID, tx_data_TLAST
    );
endinterface

// File: rtl/top_k_sorter.sv
// K-deep sorted register array keeping the K largest unsigned values of a
// frame. On TLAST the retained values stream out in descending order, then
// the array clears for the next frame. Slot 0 holds the largest value; the
// valid slots are always the contiguous prefix 0..occupancy-1.
module top_k_sorter #(
    parameter int INTEGER_SIZE = 32,
    parameter int K            = 8,
    parameter int CNT_W        = $clog2(K + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    top_k_sorter_if.slave    s,
    output logic [CNT_W-1:0] occupancy,
    output logic             busy
);
    typedef enum logic {ACCEPT = 1'b0, DRAIN = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [INTEGER_SIZE-1:0] slot_q [K];
    logic [INTEGER_SIZE-1:0] slot_d [K];
    logic [CNT_W-1:0]        occ_q, occ_d;
    logic [CNT_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic [INTEGER_SIZE-1:0] rx_val;
    logic                    rx_clr;
    logic                    rx_fire;
    logic                    tx_fire;
    logic                    tx_last;
    logic                    ins_found;
    int                      ins_idx;

    assign rx_val  = s.rx_data_TDATA[INTEGER_SIZE-1:0];
    assign rx_clr  = s.rx_data_TDATA[INTEGER_SIZE];
    // Ready is forced low while reset is held so no beat can slip in
    assign s.rx_data_TREADY = rst_n && (state_q == ACCEPT);
    assign rx_fire = s.rx_data_TVALID && s.rx_data_TREADY;

    assign tx_last = (state_q == DRAIN) && ((ptr_q + CNT_W'(1)) == cnt_q);
    assign tx_fire = s.tx_data_TVALID && s.tx_data_TREADY;

    assign s.tx_data_TVALID = (state_q == DRAIN);
    assign s.tx_data_TLAST  = tx_last;
    assign occupancy        = occ_q;
    assign busy             = (state_q == DRAIN);

    // Drain output mux; zero outside DRAIN so nothing leaks between frames
    always_comb begin
        s.tx_data_TDATA = '0;
        if (state_q == DRAIN) begin
            for (int i = 0; i < K; i++) begin
                if (CNT_W'(i) == ptr_q) s.tx_data_TDATA = slot_q[i];
            end
        end
    end

    // Insert position: first empty slot or first slot strictly smaller than v,
    // so equal values land below earlier arrivals
    always_comb begin
        ins_found = 1'b0;
        ins_idx   = 0;
        for (int i = 0; i < K; i++) begin
            if (!ins_found && ((CNT_W'(i) >= occ_q) || (rx_val > slot_q[i]))) begin
                ins_found = 1'b1;
                ins_idx   = i;
            end
        end
    end

    // Next-state: insert/clear in ACCEPT, pointer walk and final clear in DRAIN
    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        occ_d   = occ_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACCEPT: begin
                if (rx_fire) begin
                    if (rx_clr) begin
                        for (int j = 0; j < K; j++) slot_d[j] = '0;
                        occ_d = '0;
                    end else begin
                        if (ins_found) begin
                            for (int j = 1; j < K; j++) begin
                                if (j > ins_idx) slot_d[j] = slot_q[j-1];
                            end
                            for (int j = 0; j < K; j++) begin
                                if (j == ins_idx) slot_d[j] = rx_val;
                            end
                        end
                        if (occ_q != CNT_W'(K)) occ_d = occ_q + CNT_W'(1);
                        if (s.rx_data_TLAST) begin
                            state_d = DRAIN;
                            ptr_d   = '0;
                            cnt_d   = occ_d;
                        end
                    end
                end
            end
            DRAIN: begin
                if (tx_fire) begin
                    ptr_d = ptr_q + CNT_W'(1);
                    if (tx_last) begin
                        for (int j = 0; j < K; j++) slot_d[j] = '0;
                        occ_d   = '0;
                        ptr_d   = '0;
                        cnt_d   = '0;
                        state_d = ACCEPT;
                    end
                end
            end
            default: state_d = ACCEPT;
        endcase
    end

    // State and array registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACCEPT;
            occ_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            for (int j = 0; j < K; j++) slot_q[j] <= '0;
        end else begin
            state_q <= state_d;
            occ_q   <= occ_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            for (int j = 0; j < K; j++) slot_q[j] <= slot_d[j];
        end
    end
endmodule

// File: tb/tb_top_k_sorter.sv
// Bench for top_k_sorter with K=4: table of frames plus directed sequences
// for clear, backpressure and reset during drain.
module tb_top_k_sorter;
    localparam int W     = 32;
    localparam int K     = 4;
    localparam int CNT_W = $clog2(K + 1);

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] occupancy;
    logic             busy;

    top_k_sorter_if #(.INTEGER_SIZE(W)) bus ();

    top_k_sorter #(.INTEGER_SIZE(W), .K(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (bus.slave),
        .occupancy (occupancy),
        .busy      (busy)
    );

    // ---------------- clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q [$];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // ---------------- driver tasks (called at a negedge, return at a negedge)
    task automatic send(input logic [W-1:0] v, input logic clr, input logic last);
        int n;
        bus.rx_data_TDATA  = {clr, v};
        bus.rx_data_TLAST  = last;
        bus.rx_data_TVALID = 1'b1;
        n = 0;
        while (!bus.rx_data_TREADY && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rx_accept_timeout", {31'd0, n >= 200}, 0);
        @(negedge clk);
        bus.rx_data_TVALID = 1'b0;
        bus.rx_data_TLAST  = 1'b0;
    endtask

    task automatic recv(input logic [W-1:0] ev, input logic el);
        int n;
        bus.tx_data_TREADY = 1'b1;
        n = 0;
        while (!bus.tx_data_TVALID && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tx_valid_timeout", {31'd0, n >= 200}, 0);
        check("tx_data", bus.tx_data_TDATA, ev);
        check("tx_last", {31'd0, bus.tx_data_TLAST}, {31'd0, el});
        @(negedge clk);
    endtask

    // Drain everything queued in the scoreboard, TLAST expected on the final one
    task automatic drain_expected();
        logic [W-1:0] ev;
        while (exp_q.size() > 0) begin
            ev = exp_q.pop_front();
            recv(ev, exp_q.size() == 0);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_occ"},   {28'd0, occupancy}, 0);
        check({tag, "_busy"},  {31'd0, busy}, 0);
        check({tag, "_txv"},   {31'd0, bus.tx_data_TVALID}, 0);
        check({tag, "_rxrdy"}, {31'd0, bus.rx_data_TREADY}, 1);
    endtask

    // ---------------- vector table
    typedef struct {
        int           n_in;
        logic [W-1:0] vin [6];
        int           n_out;
        logic [W-1:0] vout [4];
    } vec_t;

    vec_t tbl [3];

    initial begin
        logic [W-1:0] prev_d;
        logic         prev_l;
        logic         stalled;
        logic         done;
        int           cyc;

        tbl[0].n_in = 5; tbl[0].vin = '{5, 9, 1, 7, 3, 0};
        tbl[0].n_out = 4; tbl[0].vout = '{9, 7, 5, 3};
        tbl[1].n_in = 2; tbl[1].vin = '{2, 8, 0, 0, 0, 0};
        tbl[1].n_out = 2; tbl[1].vout = '{8, 2, 0, 0};
        // Equal 4s keep arrival order; 1 is dropped once the array is full
        tbl[2].n_in = 6; tbl[2].vin = '{4, 4, 6, 4, 4, 1};
        tbl[2].n_out = 4; tbl[2].vout = '{6, 4, 4, 4};

        rst_n = 1'b0;
        bus.rx_data_TDATA  = '0;
        bus.rx_data_TVALID = 1'b0;
        bus.rx_data_TLAST  = 1'b0;
        bus.tx_data_TREADY = 1'b1;
        repeat (3) @(negedge clk);

        // ---- reset state
        check("rst_rxrdy", {31'd0, bus.rx_data_TREADY}, 0);
        check("rst_txv",   {31'd0, bus.tx_data_TVALID}, 0);
        check("rst_txl",   {31'd0, bus.tx_data_TLAST}, 0);
        check("rst_txd",   bus.tx_data_TDATA, 0);
        check("rst_occ",   {28'd0, occupancy}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_rst");

        // ---- table frames
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < tbl[t].n_in - 1; i++) send(tbl[t].vin[i], 1'b0, 1'b0);
            check("pre_last_txv", {31'd0, bus.tx_data_TVALID}, 0);
            send(tbl[t].vin[tbl[t].n_in-1], 1'b0, 1'b1);
            // One cycle after TLAST acceptance the first result is presented
            check("first_txv", {31'd0, bus.tx_data_TVALID}, 1);
            check("drain_busy", {31'd0, busy}, 1);
            check("drain_occ", {28'd0, occupancy}, tbl[t].n_out);
            for (int i = 0; i < tbl[t].n_out; i++) exp_q.push_back(tbl[t].vout[i]);
            drain_expected();
            check_idle("tbl_end");
        end

        // ---- clear beat (flag set, TLAST ignored)
        send(10, 1'b0, 1'b0);
        send(20, 1'b0, 1'b0);
        check("clr_occ_before", {28'd0, occupancy}, 2);
        send(77, 1'b1, 1'b1);
        check("clr_occ_after", {28'd0, occupancy}, 0);
        check("clr_busy", {31'd0, busy}, 0);
        send(3, 1'b0, 1'b1);
        exp_q.push_back(3);
        drain_expected();
        check_idle("clr_end");

        // ---- backpressure with the next frame waiting on rx
        for (int i = 1; i <= 4; i++) send(i, 1'b0, 1'b0);
        send(5, 1'b0, 1'b1);
        exp_q = '{5, 4, 3, 2};
        bus.rx_data_TDATA  = {1'b0, 32'd42};
        bus.rx_data_TLAST  = 1'b0;
        bus.rx_data_TVALID = 1'b1;
        stalled = 1'b0;
        done    = 1'b0;
        prev_d  = '0;
        prev_l  = 1'b0;
        cyc     = 0;
        while (!done && cyc < 100) begin
            bus.tx_data_TREADY = cyc[0];
            check("bp_rxrdy", {31'd0, bus.rx_data_TREADY}, 0);
            check("bp_txv", {31'd0, bus.tx_data_TVALID}, 1);
            if (stalled) begin
                check("bp_hold_data", bus.tx_data_TDATA, prev_d);
                check("bp_hold_last", {31'd0, bus.tx_data_TLAST}, {31'd0, prev_l});
            end
            if (bus.tx_data_TREADY) begin
                check("bp_data", bus.tx_data_TDATA, exp_q.pop_front());
                check("bp_last", {31'd0, bus.tx_data_TLAST}, {31'd0, exp_q.size() == 0});
                if (exp_q.size() == 0) done = 1'b1;
            end
            stalled = !bus.tx_data_TREADY;
            prev_d  = bus.tx_data_TDATA;
            prev_l  = bus.tx_data_TLAST;
            @(negedge clk);
            cyc++;
        end
        check("bp_timeout", {31'd0, !done}, 0);
        bus.tx_data_TREADY = 1'b1;
        check("bp_rx_resume", {31'd0, bus.rx_data_TREADY}, 1);
        check("bp_occ_clear", {28'd0, occupancy}, 0);
        @(negedge clk);
        bus.rx_data_TVALID = 1'b0;
        check("bp_held_beat_in", {28'd0, occupancy}, 1);
        send(17, 1'b0, 1'b1);
        exp_q = '{42, 17};
        drain_expected();
        check_idle("bp_end");

        // ---- reset during drain
        send(11, 1'b0, 1'b0);
        send(22, 1'b0, 1'b0);
        send(33, 1'b0, 1'b0);
        send(44, 1'b0, 1'b1);
        recv(44, 1'b0);
        recv(33, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_txv",  {31'd0, bus.tx_data_TVALID}, 0);
        check("mid_rst_txl",  {31'd0, bus.tx_data_TLAST}, 0);
        check("mid_rst_txd",  bus.tx_data_TDATA, 0);
        check("mid_rst_occ",  {28'd0, occupancy}, 0);
        check("mid_rst_busy", {31'd0, busy}, 0);
        check("mid_rst_rxrdy", {31'd0, bus.rx_data_TREADY}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(7, 1'b0, 1'b1);
        exp_q.push_back(7);
        drain_expected();
        check_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
